// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared state, select and function constants for datapath_ctrl
package datapath_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_OP_B  = 3'd2,
      ST_OP_C  = 3'd3,
      ST_OP_D  = 3'd4,
      ST_CHECK = 3'd5,
      ST_DONE  = 3'd6,
      ST_ERR   = 3'd7
   } state_t;

   localparam logic [1:0] SEL_B = 2'b00;
   localparam logic [1:0] SEL_C = 2'b01;
   localparam logic [1:0] SEL_D = 2'b10;

   localparam logic [2:0] PASS_FN_DEFAULT = 3'b000;

endpackage

// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - request/status and datapath control bundle for datapath_ctrl
interface datapath_ctrl_if;

   logic       start;
   logic [2:0] op_en;
   logic [2:0] fn_b;
   logic [2:0] fn_c;
   logic [2:0] fn_d;
   logic [3:0] passes;
   logic       ovf;
   logic       s2;
   logic       s1;
   logic       s0;
   logic       f2;
   logic       f1;
   logic       f0;
   logic       busy;
   logic       done;
   logic       err;
   logic       ovf_seen;

   modport master (
      output start, op_en, fn_b, fn_c, fn_d, passes, ovf,
      input  s2, s1, s0, f2, f1, f0, busy, done, err, ovf_seen
   );

   modport slave (
      input  start, op_en, fn_b, fn_c, fn_d, passes, ovf,
      output s2, s1, s0, f2, f1, f0, busy, done, err, ovf_seen
   );

endinterface

// File: rtl/datapath_ctrl_op_step_sel.sv
// rtl/datapath_ctrl_op_step_sel.sv - finds the next enabled operand step after the current state
module op_step_sel
   import datapath_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [2:0] i_op_en,
   output logic       o_found,
   output state_t     o_next
);

   // Any non-OP state asks for the first enabled operand of a pass.
   always_comb begin
      o_found = 1'b0;
      o_next  = ST_CHECK;
      case (i_state)
         ST_OP_B: begin
            if (i_op_en[1]) begin
               o_found = 1'b1;
               o_next  = ST_OP_C;
            end else if (i_op_en[2]) begin
               o_found = 1'b1;
               o_next  = ST_OP_D;
            end
         end
         ST_OP_C: begin
            if (i_op_en[2]) begin
               o_found = 1'b1;
               o_next  = ST_OP_D;
            end
         end
         ST_OP_D: begin
            o_found = 1'b0;
         end
         default: begin
            if (i_op_en[0]) begin
               o_found = 1'b1;
               o_next  = ST_OP_B;
            end else if (i_op_en[1]) begin
               o_found = 1'b1;
               o_next  = ST_OP_C;
            end else if (i_op_en[2]) begin
               o_found = 1'b1;
               o_next  = ST_OP_D;
            end
         end
      endcase
   end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - Moore sequencer driving datapath mux selects and ALU function
module datapath_ctrl
   import datapath_ctrl_pkg::*;
#(
   parameter logic [2:0] PASS_FN      = PASS_FN_DEFAULT,
   parameter bit         ABORT_ON_OVF = 1'b1
)(
   input  logic            i_clk,
   input  logic            i_reset,
   datapath_ctrl_if.slave  bus
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_pass_cnt;
   logic       r_ovf_seen;
   logic [2:0] r_op_en;
   logic [2:0] r_fn_b;
   logic [2:0] r_fn_c;
   logic [2:0] r_fn_d;
   logic [3:0] r_passes;

   logic       w_found;
   state_t     w_step;
   logic [4:0] w_cnt_inc;
   logic [4:0] w_passes_eff;
   logic [1:0] w_sel;
   logic       w_s0;
   logic [2:0] w_fn;
   logic       w_accept;
   logic       w_in_op;

   op_step_sel u_step (
      .i_state (r_state),
      .i_op_en (r_op_en),
      .o_found (w_found),
      .o_next  (w_step)
   );

   assign w_cnt_inc    = {1'b0, r_pass_cnt} + 5'd1;
   assign w_passes_eff = (r_passes == 4'd0) ? 5'd1 : {1'b0, r_passes};
   assign w_accept     = (r_state == ST_IDLE) && bus.start;
   assign w_in_op      = (r_state == ST_OP_B) || (r_state == ST_OP_C) || (r_state == ST_OP_D);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_sel  = SEL_B;
      w_s0   = 1'b0;
      w_fn   = PASS_FN;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_s0   = 1'b1;
            w_next = w_found ? w_step : ST_DONE;
         end
         ST_OP_B, ST_OP_C, ST_OP_D: begin
            if (r_state == ST_OP_B) begin
               w_sel = SEL_B;
               w_fn  = r_fn_b;
            end else if (r_state == ST_OP_C) begin
               w_sel = SEL_C;
               w_fn  = r_fn_c;
            end else begin
               w_sel = SEL_D;
               w_fn  = r_fn_d;
            end
            if (ABORT_ON_OVF && bus.ovf) w_next = ST_ERR;
            else                         w_next = w_found ? w_step : ST_CHECK;
         end
         ST_CHECK: begin
            w_next = (w_cnt_inc < w_passes_eff) ? w_step : ST_DONE;
         end
         ST_DONE, ST_ERR: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Operands are captured only on the accepting edge so bus changes mid-sequence are ignored.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pass_cnt <= 4'd0;
         r_ovf_seen <= 1'b0;
         r_op_en    <= 3'd0;
         r_fn_b     <= PASS_FN;
         r_fn_c     <= PASS_FN;
         r_fn_d     <= PASS_FN;
         r_passes   <= 4'd0;
      end else if (w_accept) begin
         r_pass_cnt <= 4'd0;
         r_ovf_seen <= 1'b0;
         r_op_en    <= bus.op_en;
         r_fn_b     <= bus.fn_b;
         r_fn_c     <= bus.fn_c;
         r_fn_d     <= bus.fn_d;
         r_passes   <= bus.passes;
      end else if (w_in_op) begin
         r_ovf_seen <= r_ovf_seen | bus.ovf;
      end else if (r_state == ST_CHECK) begin
         r_pass_cnt <= w_cnt_inc[3:0];
      end
   end

   assign bus.s2       = w_sel[1];
   assign bus.s1       = w_sel[0];
   assign bus.s0       = w_s0;
   assign bus.f2       = w_fn[2];
   assign bus.f1       = w_fn[1];
   assign bus.f0       = w_fn[0];
   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.done     = (r_state == ST_DONE) || (r_state == ST_ERR);
   assign bus.err      = (r_state == ST_ERR);
   assign bus.ovf_seen = r_ovf_seen;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   datapath_ctrl_if ifa ();
   datapath_ctrl_if ifc ();

   datapath_ctrl #(.PASS_FN(3'b000), .ABORT_ON_OVF(1'b1)) dut_a (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (ifa)
   );

   datapath_ctrl #(.PASS_FN(3'b000), .ABORT_ON_OVF(1'b0)) dut_c (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (ifc)
   );

   // {busy, done, err, ovf_seen, s2, s1, s0, f2, f1, f0}
   logic [9:0] obs_a;
   logic [9:0] obs_c;
   assign obs_a = {ifa.busy, ifa.done, ifa.err, ifa.ovf_seen, ifa.s2, ifa.s1, ifa.s0, ifa.f2, ifa.f1, ifa.f0};
   assign obs_c = {ifc.busy, ifc.done, ifc.err, ifc.ovf_seen, ifc.s2, ifc.s1, ifc.s0, ifc.f2, ifc.f1, ifc.f0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] mk(input logic busy, input logic done, input logic err,
                                     input logic ovfs, input logic [2:0] sel, input logic [2:0] f);
      return {busy, done, err, ovfs, sel, f};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic setup_a(input logic [2:0] en, input logic [2:0] fb, input logic [2:0] fc,
                          input logic [2:0] fd, input logic [3:0] np);
      ifa.op_en  = en;
      ifa.fn_b   = fb;
      ifa.fn_c   = fc;
      ifa.fn_d   = fd;
      ifa.passes = np;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      ifa.start = 1'b0; ifa.ovf = 1'b0; setup_a(3'b000, 3'b000, 3'b000, 3'b000, 4'd0);
      ifc.start = 1'b0; ifc.ovf = 1'b0;
      ifc.op_en = 3'b000; ifc.fn_b = 3'b000; ifc.fn_c = 3'b000; ifc.fn_d = 3'b000; ifc.passes = 4'd0;
      tick();
      tick();
      chk("reset_a", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));
      chk("reset_c", obs_c, mk(0, 0, 0, 0, 3'b000, 3'b000));
      reset = 1'b0;

      // full single pass
      setup_a(3'b111, 3'b001, 3'b010, 3'b011, 4'd1);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("full_load", obs_a, mk(1, 0, 0, 0, 3'b001, 3'b000));
      tick(); chk("full_op_b", obs_a, mk(1, 0, 0, 0, 3'b000, 3'b001));
      tick(); chk("full_op_c", obs_a, mk(1, 0, 0, 0, 3'b010, 3'b010));
      tick(); chk("full_op_d", obs_a, mk(1, 0, 0, 0, 3'b100, 3'b011));
      tick(); chk("full_check", obs_a, mk(1, 0, 0, 0, 3'b000, 3'b000));
      tick(); chk("full_done", obs_a, mk(1, 1, 0, 0, 3'b000, 3'b000));
      tick(); chk("full_idle", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));

      // sparse operands, three passes, inputs scrambled while busy
      setup_a(3'b101, 3'b100, 3'b111, 3'b110, 4'd3);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      setup_a(3'b010, 3'b111, 3'b001, 3'b001, 4'd0);
      chk("sparse_load", obs_a, mk(1, 0, 0, 0, 3'b001, 3'b000));
      for (int p = 0; p < 3; p++) begin
         tick(); chk($sformatf("sparse_op_b_p%0d", p), obs_a, mk(1, 0, 0, 0, 3'b000, 3'b100));
         tick(); chk($sformatf("sparse_op_d_p%0d", p), obs_a, mk(1, 0, 0, 0, 3'b100, 3'b110));
         tick(); chk($sformatf("sparse_check_p%0d", p), obs_a, mk(1, 0, 0, 0, 3'b000, 3'b000));
      end
      tick(); chk("sparse_done", obs_a, mk(1, 1, 0, 0, 3'b000, 3'b000));
      tick(); chk("sparse_idle", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));

      // empty operand set, passes = 0
      setup_a(3'b000, 3'b011, 3'b011, 3'b011, 4'd0);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("empty_load", obs_a, mk(1, 0, 0, 0, 3'b001, 3'b000));
      tick(); chk("empty_done", obs_a, mk(1, 1, 0, 0, 3'b000, 3'b000));
      tick(); chk("empty_idle", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));

      // overflow abort during OP_C
      setup_a(3'b111, 3'b001, 3'b010, 3'b011, 4'd2);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("abort_load", obs_a, mk(1, 0, 0, 0, 3'b001, 3'b000));
      tick(); chk("abort_op_b", obs_a, mk(1, 0, 0, 0, 3'b000, 3'b001));
      tick(); chk("abort_op_c", obs_a, mk(1, 0, 0, 0, 3'b010, 3'b010));
      ifa.ovf = 1'b1;
      tick();
      ifa.ovf = 1'b0;
      chk("abort_err", obs_a, mk(1, 1, 1, 1, 3'b000, 3'b000));
      tick(); chk("abort_idle", obs_a, mk(0, 0, 0, 1, 3'b000, 3'b000));
      tick(); chk("abort_idle2", obs_a, mk(0, 0, 0, 1, 3'b000, 3'b000));

      // ovf_seen cleared by the next accepted start
      setup_a(3'b000, 3'b000, 3'b000, 3'b000, 4'd1);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("clr_load", obs_a, mk(1, 0, 0, 0, 3'b001, 3'b000));
      tick(); chk("clr_done", obs_a, mk(1, 1, 0, 0, 3'b000, 3'b000));
      tick(); chk("clr_idle", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));

      // overflow continue plus start while busy
      ifc.op_en = 3'b111; ifc.fn_b = 3'b001; ifc.fn_c = 3'b010; ifc.fn_d = 3'b011; ifc.passes = 4'd1;
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      chk("cont_load", obs_c, mk(1, 0, 0, 0, 3'b001, 3'b000));
      tick(); chk("cont_op_b", obs_c, mk(1, 0, 0, 0, 3'b000, 3'b001));
      ifc.ovf = 1'b1;
      tick();
      ifc.ovf = 1'b0;
      chk("cont_op_c", obs_c, mk(1, 0, 0, 1, 3'b010, 3'b010));
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      chk("cont_op_d", obs_c, mk(1, 0, 0, 1, 3'b100, 3'b011));
      tick(); chk("cont_check", obs_c, mk(1, 0, 0, 1, 3'b000, 3'b000));
      tick(); chk("cont_done", obs_c, mk(1, 1, 0, 1, 3'b000, 3'b000));
      tick(); chk("cont_idle", obs_c, mk(0, 0, 0, 1, 3'b000, 3'b000));
      tick(); chk("cont_no_relaunch", obs_c, mk(0, 0, 0, 1, 3'b000, 3'b000));

      // reset mid-sequence in OP_C
      setup_a(3'b111, 3'b001, 3'b010, 3'b011, 4'd1);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      tick(); chk("rmid_op_b", obs_a, mk(1, 0, 0, 0, 3'b000, 3'b001));
      tick(); chk("rmid_op_c", obs_a, mk(1, 0, 0, 0, 3'b010, 3'b010));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rmid_a", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));
      chk("rmid_c_ovf_cleared", obs_c, mk(0, 0, 0, 0, 3'b000, 3'b000));
      tick(); chk("rmid_a_stays_idle", obs_a, mk(0, 0, 0, 0, 3'b000, 3'b000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
